// File: rtl/fft_sample_loader.sv
// fft_sample_loader: collects an interleaved byte stream (re, im, re, im, ...)
// into an N-entry complex frame buffer, then streams the frame to a
// downstream FFT with a valid/ready handshake.
//
// Parameters
//   FRAME_LOG2  log2 of samples per frame (N = 2**FRAME_LOG2, N >= 2)
//   DATA_W      width of the input byte and of each real/imag part
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_data/in_valid      input byte stream
//   in_ready              high while filling (FILL state)
//   flush                 drop the partial frame (ignored while draining)
//   out_re/out_im         current output sample, read straight from the buffer
//   out_valid/out_ready   output handshake
//   out_last              current sample is the last of the frame
//   frame_count           completed frames, modulo 256
// Configuration
//   LOADER_BITREV_EN      when defined, samples are written at the bit-reversed
//                         index so the frame drains in bit-reversed order.
module fft_sample_loader #(
  parameter int unsigned FRAME_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        frame_count
);

  localparam int unsigned N = 1 << FRAME_LOG2;
  localparam logic [FRAME_LOG2-1:0] LAST_IDX = FRAME_LOG2'(N - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [FRAME_LOG2-1:0] wr_idx_q, wr_idx_d;
  logic [FRAME_LOG2-1:0] rd_idx_q, rd_idx_d;
  logic [FRAME_LOG2-1:0] wr_addr;
  logic                  phase_q, phase_d;
  logic [7:0]            frame_count_d;
  logic                  in_ready_d, out_valid_d, out_last_d;
  logic                  hold_en, wr_en;
  logic [DATA_W-1:0]     re_hold_q;
  logic [2*DATA_W-1:0]   mem [N];

`ifdef LOADER_BITREV_EN
  // Bit-reversed write address for in-place radix-2 DIT ordering.
  function automatic logic [FRAME_LOG2-1:0] bitrev(input logic [FRAME_LOG2-1:0] idx);
    logic [FRAME_LOG2-1:0] r;
    for (int unsigned b = 0; b < FRAME_LOG2; b++) begin
      r[b] = idx[FRAME_LOG2-1-b];
    end
    return r;
  endfunction
  assign wr_addr = bitrev(wr_idx_q);
`else
  assign wr_addr = wr_idx_q;
`endif

  // State register plus registered indices and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      phase_q     <= 1'b0;
      frame_count <= 8'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      phase_q     <= phase_d;
      frame_count <= frame_count_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_last    <= out_last_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    phase_d       = phase_q;
    frame_count_d = frame_count;
    hold_en       = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      FILL: begin
        if (flush) begin
          wr_idx_d = '0;
          phase_d  = 1'b0;
        end else if (in_valid) begin
          if (!phase_q) begin
            hold_en = 1'b1;
            phase_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            phase_d = 1'b0;
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_d = '0;
              state_d  = DRAIN;
            end else begin
              wr_idx_d = wr_idx_q + FRAME_LOG2'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d      = '0;
            state_d       = FILL;
            frame_count_d = frame_count + 8'd1;
          end else begin
            rd_idx_d = rd_idx_q + FRAME_LOG2'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (rd_idx_d == LAST_IDX);
  end

  // Holding register for the real part of the pending pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_hold_q <= '0;
    end else if (hold_en) begin
      re_hold_q <= in_data;
    end
  end

  // Frame buffer: contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {re_hold_q, in_data};
    end
  end

  assign out_re = mem[rd_idx_q][2*DATA_W-1:DATA_W];
  assign out_im = mem[rd_idx_q][DATA_W-1:0];

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader (default parameters). A
// transaction-level model (byte queue -> frame -> drain order) predicts
// every output on every cycle; directed scenarios add literal expectations.
// Honours LOADER_BITREV_EN in the same way as the design.
module tb_fft_sample_loader;
  localparam int N  = 16;
  localparam int LG = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] out_re, out_im;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic [7:0] frame_count;

  fft_sample_loader #(.FRAME_LOG2(LG), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_re(out_re), .out_im(out_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  bit         m_fill = 1'b1;
  logic [7:0] m_q[$];
  logic [7:0] exp_re[N];
  logic [7:0] exp_im[N];
  int         m_pos = 0;
  logic [7:0] m_fc = 8'd0;
  logic [7:0] obs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int i);
    int r = 0;
    for (int b = 0; b < LG; b++) if (i[b]) r = r | (1 << (LG - 1 - b));
    return r;
  endfunction

  // Drain position p presents input sample k.
  function automatic int src_of(input int p);
`ifdef LOADER_BITREV_EN
    return rev(p);
`else
    return p;
`endif
  endfunction

  task automatic model_reset();
    m_fill = 1'b1; m_q.delete(); m_pos = 0; m_fc = 8'd0;
  endtask

  // Apply one cycle of inputs, advance the model on the rising edge.
  task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    if (out_valid && r) obs.push_back(out_re);
    @(posedge clk);
    if (m_fill) begin
      if (f) m_q.delete();
      else if (v) begin
        m_q.push_back(d);
        if (m_q.size() == 2 * N) begin
          for (int p = 0; p < N; p++) begin
            exp_re[p] = m_q[2 * src_of(p)];
            exp_im[p] = m_q[2 * src_of(p) + 1];
          end
          m_q.delete(); m_fill = 1'b0; m_pos = 0;
        end
      end
    end else if (r) begin
      if (m_pos == N - 1) begin
        m_pos = 0; m_fill = 1'b1; m_fc = m_fc + 8'd1;
      end else m_pos++;
    end
    @(negedge clk);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("in_ready", int'(in_ready), int'(m_fill));
    check("out_valid", int'(out_valid), int'(!m_fill));
    check("out_last", int'(out_last), int'(!m_fill && m_pos == N - 1));
    check("frame_count", int'(frame_count), int'(m_fc));
    if (!m_fill) begin
      check("out_re", int'(out_re), int'(exp_re[m_pos]));
      check("out_im", int'(out_im), int'(exp_im[m_pos]));
    end
  end

  // Run one full frame with random handshakes; returns cycles taken.
  task automatic run_frame(input int vp, input int rp, input int fp, output int cyc);
    logic [7:0] start = m_fc;
    cyc = 0;
    while (m_fc == start && cyc < 4000) begin
      step($urandom_range(99) < vp, 8'($urandom), $urandom_range(99) < fp,
           $urandom_range(99) < rp);
      cyc++;
    end
    if (m_fc == start) check("frame_timeout", cyc, -1);
  endtask

  initial begin
    int cyc;
    int exp_br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_frame_count", int'(frame_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed frame: re=k, im=0x80+k, out_ready held high.
    for (int k = 0; k < N; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b1);
      step(1'b1, 8'(8'h80 + k), 1'b0, 1'b1);
    end
    check("fill_to_drain_1cyc", int'(out_valid), 1);
    obs.delete();
    for (int k = 0; k < N; k++) step(1'b0, 8'd0, 1'b0, 1'b1);
    check("frame_count_after_1", int'(frame_count), 1);
    check("drain_to_fill_1cyc", int'(in_ready), 1);
    check("obs_count", obs.size(), N);
    for (int k = 0; k < N && k < obs.size(); k++) begin
`ifdef LOADER_BITREV_EN
      check("order_lit", int'(obs[k]), exp_br[k]);
`else
      check("order_lit", int'(obs[k]), k);
`endif
    end

    // Backpressure mid-drain with ignored in_valid pulses.
    for (int k = 0; k < 2 * N; k++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(k % 2 == 0, 8'($urandom), 1'b0, 1'b0);
    check("hold_valid", int'(out_valid), 1);
    check("hold_in_ready", int'(in_ready), 0);
    check("hold_re_lit", int'(out_re), int'(exp_re[4]));
    for (int k = 0; k < 12; k++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
    check("frame_count_after_2", int'(frame_count), 2);

    // Flush with the 8th byte, then a fresh frame, then flush during drain.
    for (int k = 0; k < 7; k++) step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) begin
      step(1'b1, 8'(8'h40 + k), 1'b0, 1'b1);
      step(1'b1, 8'(8'hC0 + k), 1'b0, 1'b1);
    end
    check("flush_first_re_lit", int'(out_re), 'h40);
    check("flush_first_im_lit", int'(out_im), 'hC0);
    for (int k = 0; k < N; k++) step(1'b1, 8'd0, 1'b1, 1'b1);
    check("flush_in_drain_done", int'(frame_count), 3);

    // Reset at drain sample 9.
    for (int k = 0; k < 2 * N; k++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 8'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_out_last", int'(out_last), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 257 back-to-back frames, each exactly 2N fill + N drain cycles.
    for (int f = 0; f < 257; f++) begin
      run_frame(100, 100, 0, cyc);
      if (f < 4 || f == 256) check("b2b_cycles", cyc, 3 * N);
    end
    check("frame_count_wrap", int'(frame_count), 1);

    // Randomized handshakes with occasional flushes.
    for (int f = 0; f < 30; f++) run_frame(70, 60, 2, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
